mac_drain: RTL and testbench

Result drain for a row of `Mac` accumulators; the consumer end of the MAC accumulation path. On `start` it snapshots `N_COLS` accumulator values in one cycle, pulses a clear back to the MAC row, then streams the captured values out one per handshake on a valid/ready port. It can optionally requantize each value to `OP_WIDTH`. It sits between the MAC array and the output/writeback buffer.

---
 rtl/mac_drain_pkg.sv | 33 +++
 rtl/mac_requant.sv | 23 ++
 rtl/mac_drain.sv | 113 +++++++++++
 tb/tb_mac_drain.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_drain_pkg.sv
// Shared types and helpers for the mac_drain result path.
// MAC_DRAIN_REQUANT_EN selects the requantized (OP_WIDTH) output width.
package mac_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int N_COLS_DEF      = 4;
  localparam int OP_WIDTH_DEF    = 8;
  localparam int ACC_WIDTH_DEF   = 32;
  localparam int SHIFT_WIDTH_DEF = 5;

`ifdef MAC_DRAIN_REQUANT_EN
  localparam bit REQUANT_EN = 1'b1;
`else
  localparam bit REQUANT_EN = 1'b0;
`endif

  function automatic int out_width_f(input int op_width, input int acc_width);
    return REQUANT_EN ? op_width : acc_width;
  endfunction

  // Largest value representable in an unsigned operand of op_width bits.
  function automatic longint unsigned sat_limit_f(input int op_width);
    return (64'd1 << op_width) - 64'd1;
  endfunction

  localparam longint unsigned SAT_LIMIT_DEF = sat_limit_f(OP_WIDTH_DEF);

endpackage

// File: rtl/mac_requant.sv
// Combinational requantizer: logical right shift then saturate one unsigned
// accumulator value to OP_WIDTH bits. Used only under MAC_DRAIN_REQUANT_EN.
module mac_requant
  import mac_drain_pkg::*;
#(
  parameter int OP_WIDTH    = OP_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [OP_WIDTH-1:0]    q
);

  localparam logic [ACC_WIDTH-1:0] SAT_LIMIT = ACC_WIDTH'(sat_limit_f(OP_WIDTH));

  logic [ACC_WIDTH-1:0] shifted;

  // Truncating shift; the high bits left over decide saturation.
  assign shifted = acc >> shift;
  assign q       = (shifted > SAT_LIMIT) ? {OP_WIDTH{1'b1}} : shifted[OP_WIDTH-1:0];

endmodule

// File: rtl/mac_drain.sv
// Drains a row of MAC accumulators: snapshot on start, clear the row, stream
// lanes out over valid/ready. MAC_DRAIN_REQUANT_EN enables per-beat requant.
module mac_drain
  import mac_drain_pkg::*;
#(
  parameter int N_COLS      = N_COLS_DEF,
  parameter int OP_WIDTH    = OP_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  localparam int OUT_WIDTH  = out_width_f(OP_WIDTH, ACC_WIDTH),
  localparam int IDX_W      = $clog2(N_COLS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [N_COLS*ACC_WIDTH-1:0] acc_in,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  output logic                        mac_clear,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COLS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [ACC_WIDTH-1:0] cap_q [N_COLS];
  logic [ACC_WIDTH-1:0] sel;
  logic                 capture;
  logic                 fire;
  logic                 is_last;

  assign capture = (state_q == ST_IDLE) && start;
  assign fire    = out_valid && out_ready;
  assign is_last = (idx_q == LAST_IDX);

  always_comb begin
    // NOTE: default first so every path assigns state_d; a missing branch would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_STREAM;
      ST_STREAM: if (fire && is_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mac_clear <= 1'b0;
    end else begin
      state_q   <= state_d;
      mac_clear <= capture;
      if (capture) begin
        idx_q <= '0;
      end else if (fire && !is_last) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // NOTE: the capture array is reset on purpose: out_data must read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_COLS; i++) cap_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N_COLS; i++) cap_q[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  assign sel       = cap_q[idx_q];
  assign out_valid = (state_q == ST_STREAM);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_index = idx_q;
  assign out_last  = out_valid && is_last;

`ifdef MAC_DRAIN_REQUANT_EN
  logic [SHIFT_WIDTH-1:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
    end else if (capture) begin
      shift_q <= shift;
    end
  end

  mac_requant #(
    .OP_WIDTH    (OP_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_requant (
    .acc   (sel),
    .shift (shift_q),
    .q     (out_data)
  );
`else
  logic unused_shift;

  assign unused_shift = ^shift;
  assign out_data     = sel;
`endif

endmodule

// File: tb/tb_mac_drain.sv
// Randomized self-checking bench for mac_drain against a lane-queue reference
// model. Works with or without MAC_DRAIN_REQUANT_EN defined.
module tb_mac_drain;

  localparam int N_COLS      = 4;
  localparam int OP_WIDTH    = 8;
  localparam int ACC_WIDTH   = 32;
  localparam int SHIFT_WIDTH = 5;
  localparam int IDX_W       = 2;
`ifdef MAC_DRAIN_REQUANT_EN
  localparam int OUT_WIDTH = OP_WIDTH;
`else
  localparam int OUT_WIDTH = ACC_WIDTH;
`endif

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [N_COLS*ACC_WIDTH-1:0] acc_in;
  logic [SHIFT_WIDTH-1:0]      shift;
  logic                        mac_clear;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_WIDTH-1:0]        out_data;
  logic [IDX_W-1:0]            out_index;
  logic                        out_last;
  logic                        done;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [ACC_WIDTH-1:0] row_vals [N_COLS];

  mac_drain #(
    .N_COLS      (N_COLS),
    .OP_WIDTH    (OP_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .acc_in    (acc_in),
    .shift     (shift),
    .mac_clear (mac_clear),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected beat value: divide by 2^shift, clamp to the operand range.
  function automatic logic [63:0] model_f(input logic [ACC_WIDTH-1:0] x, input int sh);
`ifdef MAC_DRAIN_REQUANT_EN
    longint unsigned v;
    longint unsigned lim;
    lim = 1;
    for (int b = 0; b < OP_WIDTH; b++) lim = lim * 2;
    lim = lim - 1;
    v = longint'(x);
    for (int b = 0; b < sh; b++) v = v / 2;
    if (v > lim) v = lim;
    return 64'(v);
`else
    if (sh < 0) return 64'd0;
    return 64'(x);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input int sh);
    for (int i = 0; i < N_COLS; i++) acc_in[i*ACC_WIDTH +: ACC_WIDTH] = row_vals[i];
    shift = SHIFT_WIDTH'(sh);
  endtask

  // One full drain of row_vals; hold_lane stalls 3 cycles on that lane,
  // stall_pct adds random backpressure, poke drives stray starts.
  task automatic run_row(input string tag, input int sh, input int stall_pct,
                         input int hold_lane, input bit poke);
    logic [63:0] exp_q [$];
    int beats;
    int cycles;
    int held;
    bit rdy;
    for (int i = 0; i < N_COLS; i++) exp_q.push_back(model_f(row_vals[i], sh));
    drive_row(sh);
    start = 1'b1;
    step();
    start  = 1'b0;
    acc_in = {N_COLS{32'h0000_DEAD}};
    shift  = SHIFT_WIDTH'($urandom);
    check({tag, ".clear_k1"}, 64'(mac_clear), 64'd1);
    check({tag, ".busy_k1"}, 64'(busy), 64'd1);
    beats  = 0;
    cycles = 0;
    held   = 0;
    while (beats < N_COLS && cycles < 200) begin
      if (cycles == 1) check({tag, ".clear_k2"}, 64'(mac_clear), 64'd0);
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".data"}, 64'(out_data), exp_q[beats]);
      check({tag, ".index"}, 64'(out_index), 64'(beats));
      check({tag, ".last"}, 64'(out_last), 64'(beats == N_COLS - 1));
      if (beats == hold_lane && held < 3) begin
        rdy = 1'b0;
        held++;
      end else begin
        rdy = ($urandom_range(99) >= stall_pct);
      end
      out_ready = rdy;
      start     = poke ? 1'($urandom_range(1)) : 1'b0;
      if (rdy) beats++;
      cycles++;
      step();
    end
    check({tag, ".no_timeout"}, 64'(cycles < 200), 64'd1);
    if (stall_pct == 0 && hold_lane < 0) check({tag, ".throughput"}, 64'(cycles), 64'(N_COLS));
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".valid_done"}, 64'(out_valid), 64'd0);
    check({tag, ".busy_done"}, 64'(busy), 64'd1);
    out_ready = 1'($urandom_range(1));
    start     = poke;
    step();
    start = 1'b0;
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".busy_idle"}, 64'(busy), 64'd0);
    check({tag, ".valid_idle"}, 64'(out_valid), 64'd0);
    check({tag, ".clear_idle"}, 64'(mac_clear), 64'd0);
    out_ready = 1'b1;
    step();
    check({tag, ".still_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    acc_in    = '0;
    shift     = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.clear", 64'(mac_clear), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.last", 64'(out_last), 64'd0);
    check("rst.index", 64'(out_index), 64'd0);
    check("rst.data", 64'(out_data), 64'd0);
    reset = 1'b0;
    step();

    row_vals[0] = 32'h10;
    row_vals[1] = 32'h100;
    row_vals[2] = 32'hFFF;
    row_vals[3] = 32'h12345;
    run_row("plan", 4, 0, -1, 1'b0);
    run_row("bp", 4, 0, 1, 1'b0);
    run_row("poke", 4, 0, -1, 1'b1);

    // Reset mid-row, after lanes 0 and 1 have transferred.
    drive_row(3);
    start = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("mid.index_pre", 64'(out_index), 64'd2);
    reset     = 1'b1;
    out_ready = 1'b0;
    step();
    check("mid.valid", 64'(out_valid), 64'd0);
    check("mid.busy", 64'(busy), 64'd0);
    check("mid.clear", 64'(mac_clear), 64'd0);
    check("mid.index", 64'(out_index), 64'd0);
    check("mid.data", 64'(out_data), 64'd0);
    reset = 1'b0;
    step();
    for (int i = 0; i < N_COLS; i++) row_vals[i] = $urandom;
    run_row("post_rst", 2, 0, -1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N_COLS; i++) row_vals[i] = $urandom >> $urandom_range(31);
      run_row("rand", int'($urandom_range(31)), 35, int'($urandom_range(N_COLS)) - 1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
